// File: rtl/mem_sp_pipe_if.sv
// Request/response bus of the pipelined single-port memory: request with grant,
// response with ready, both as valid/handshake pairs.
interface mem_sp_pipe_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
);
   logic                  req;
   logic                  gnt;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   we;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_W-1:0]     rdata;
   logic                  rerr;

   modport master (
      output req, addr, wdata, we, rready,
      input  gnt, rvalid, rdata, rerr
   );

   modport slave (
      input  req, addr, wdata, we, rready,
      output gnt, rvalid, rdata, rerr
   );
endinterface

// File: rtl/mem_sp_pipe.sv
// Single-port word memory with byte-masked writes, a fixed-latency response pipeline
// and a response FIFO whose occupancy bound drives the request grant.
module mem_sp_pipe #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 12,
   parameter int DEPTH     = 4096,
   parameter int READ_LAT  = 1,
   parameter int RSP_DEPTH = 4
) (
   input logic          clock,
   input logic          reset,
   mem_sp_pipe_if.slave bus
);
   localparam int NB = DATA_W / 8;
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              acc;
   logic              in_range;
   logic              is_wr;
   logic [DATA_W-1:0] rd_word;
   logic              gnt_int;
   logic              rvalid_int;
   logic              pop;

   logic              push_vld;
   logic [DATA_W-1:0] push_dat;
   logic              push_err;

   logic [DATA_W-1:0] fifo_dat_q [RSP_DEPTH];
   logic [RSP_DEPTH-1:0] fifo_err_q;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
   logic [CW-1:0]     out_cnt_q, out_cnt_d;

   // Acceptance cycle: grant comes only from registered occupancy, read sees pre-write contents
   assign gnt_int    = reset && (out_cnt_q < CW'(RSP_DEPTH));
   assign rvalid_int = reset && (fifo_cnt_q != '0);
   assign pop        = rvalid_int && bus.rready;

   always_comb begin
      acc      = bus.req && gnt_int;
      in_range = {1'b0, bus.addr} < DEPTH_W;
      is_wr    = |bus.we;
      rd_word  = '0;
      if (in_range && !is_wr) rd_word = mem_q[bus.addr];
   end

   always_ff @(posedge clock) begin
      if (acc && is_wr && in_range) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.we[i]) mem_q[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
         end
      end
   end

   // Latency stages: READ_LAT-1 registers here, the FIFO write supplies the last cycle
   generate
      if (READ_LAT == 1) begin : g_no_pipe
         always_comb begin
            push_vld = acc;
            push_dat = rd_word;
            push_err = !in_range;
         end
      end else begin : g_pipe
         localparam int PN = READ_LAT - 1;
         logic [PN-1:0]     vld_q, vld_d;
         logic [DATA_W-1:0] dat_q [PN];
         logic [PN-1:0]     err_q;

         always_comb begin
            vld_d    = '0;
            vld_d[0] = acc;
            for (int s = 1; s < PN; s++) vld_d[s] = vld_q[s-1];
         end

         always_ff @(posedge clock) begin
            if (!reset) vld_q <= '0;
            else        vld_q <= vld_d;
         end

         always_ff @(posedge clock) begin
            dat_q[0] <= rd_word;
            err_q[0] <= !in_range;
            for (int s = 1; s < PN; s++) begin
               dat_q[s] <= dat_q[s-1];
               err_q[s] <= err_q[s-1];
            end
         end

         always_comb begin
            push_vld = vld_q[PN-1];
            push_dat = dat_q[PN-1];
            push_err = err_q[PN-1];
         end
      end
   endgenerate

   // Response FIFO: the outstanding bound keeps push-while-full paired with a pop
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (push_vld) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)      rd_ptr_d = ptr_inc(rd_ptr_q);
      fifo_cnt_d = fifo_cnt_q + CW'(push_vld) - CW'(pop);
      out_cnt_d  = out_cnt_q + CW'(acc) - CW'(pop);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         out_cnt_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         out_cnt_q  <= out_cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_vld) begin
         fifo_dat_q[wr_ptr_q] <= push_dat;
         fifo_err_q[wr_ptr_q] <= push_err;
      end
   end

   assign bus.gnt    = gnt_int;
   assign bus.rvalid = rvalid_int;
   assign bus.rdata  = rvalid_int ? fifo_dat_q[rd_ptr_q] : '0;
   assign bus.rerr   = rvalid_int && fifo_err_q[rd_ptr_q];
endmodule

// File: tb/tb_mem_sp_pipe.sv
// Bench for mem_sp_pipe: vector table, hand-written corner sequences and a random
// phase, all checked against a queue-and-array model of the memory.
module tb_mem_sp_pipe;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 12;
   localparam int DEPTH     = 3000;
   localparam int READ_LAT  = 3;
   localparam int RSP_DEPTH = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   mem_sp_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   mem_sp_pipe #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
      .READ_LAT(READ_LAT), .RSP_DEPTH(RSP_DEPTH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      logic [3:0]  we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_rerr;
   } vec_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        rerr;
   } rsp_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] mdl [DEPTH];
   rsp_t        exp_q [$];
   bit          head_hold = 0;
   rsp_t        head_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Reference model: every accept queues its expected response, every pop retires one
   always @(negedge clock) begin
      rsp_t e;
      if (!reset) begin
         chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
         chk("reset_gnt", 32'(bus.gnt), 32'd0);
         chk("reset_rdata", bus.rdata, 32'd0);
         chk("reset_rerr", 32'(bus.rerr), 32'd0);
         exp_q.delete();
         head_hold = 0;
      end else begin
         chk("gnt", 32'(bus.gnt), 32'(exp_q.size() < RSP_DEPTH));
         if (head_hold) begin
            chk("head_stable_rdata", bus.rdata, head_prev.rdata);
            chk("head_stable_rerr", 32'(bus.rerr), 32'(head_prev.rerr));
         end
         if (exp_q.size() == 0) begin
            chk("rvalid_when_empty", 32'(bus.rvalid), 32'd0);
         end else if (bus.rvalid && bus.rready) begin
            e = exp_q.pop_front();
            chk("rsp_rdata", bus.rdata, e.rdata);
            chk("rsp_rerr", 32'(bus.rerr), 32'(e.rerr));
         end
         head_hold = bus.rvalid && !bus.rready;
         head_prev = '{rdata: bus.rdata, rerr: bus.rerr};
         if (bus.req && bus.gnt) begin
            if (int'(bus.addr) >= DEPTH) begin
               e = '{rdata: 32'd0, rerr: 1'b1};
            end else if (bus.we == 4'd0) begin
               e = '{rdata: mdl[bus.addr], rerr: 1'b0};
            end else begin
               e = '{rdata: 32'd0, rerr: 1'b0};
               for (int i = 0; i < 4; i++)
                  if (bus.we[i]) mdl[bus.addr][8*i +: 8] = bus.wdata[8*i +: 8];
            end
            exp_q.push_back(e);
         end
      end
   end

   task automatic wait_gnt();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.gnt && n < 50);
      if (!bus.gnt) chk("gnt_timeout", 32'(bus.gnt), 32'd1);
   endtask

   task automatic txn(input logic [3:0] w, input logic [11:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic re, output int lat);
      int n;
      rd = '0;
      re = 1'b0;
      lat = -1;
      bus.req = 1'b1;
      bus.we = w;
      bus.addr = a;
      bus.wdata = d;
      bus.rready = 1'b1;
      wait_gnt();
      @(posedge clock);
      #1 bus.req = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.rvalid && n < 50);
      if (!bus.rvalid) chk("rsp_timeout", 32'(bus.rvalid), 32'd1);
      rd = bus.rdata;
      re = bus.rerr;
      lat = n;
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      bus.rready = 1'b1;
      while ((exp_q.size() != 0 || bus.rvalid) && n < 100) begin
         @(posedge clock);
         #1 n++;
      end
      if (n >= 100) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt [11];
      logic [31:0] rd;
      logic        re;
      int          lat, cnt, guard, idx, first_acc, last_acc, first_rv, last_rv, nrv, gaps;
      logic        acc;

      vt[0]  = '{4'hF, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0};
      vt[1]  = '{4'h0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0};
      vt[2]  = '{4'hF, 12'h020, 32'hDEADBEEF, 32'h0, 1'b0};
      vt[3]  = '{4'h5, 12'h020, 32'h11223344, 32'h0, 1'b0};
      vt[4]  = '{4'h0, 12'h020, 32'h0, 32'hDE22BE44, 1'b0};
      vt[5]  = '{4'hF, 12'h000, 32'hCAFEF00D, 32'h0, 1'b0};
      vt[6]  = '{4'h0, 12'd3000, 32'h0, 32'h0, 1'b1};
      vt[7]  = '{4'hF, 12'hFFF, 32'h12345678, 32'h0, 1'b1};
      vt[8]  = '{4'h0, 12'h000, 32'h0, 32'hCAFEF00D, 1'b0};
      vt[9]  = '{4'hF, 12'd2999, 32'hA5A55A5A, 32'h0, 1'b0};
      vt[10] = '{4'h0, 12'd2999, 32'h0, 32'hA5A55A5A, 1'b0};

      bus.req = 1'b0;
      bus.addr = '0;
      bus.wdata = '0;
      bus.we = '0;
      bus.rready = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      chk("post_reset_rvalid", 32'(bus.rvalid), 32'd0);
      chk("post_reset_gnt", 32'(bus.gnt), 32'd1);
      @(posedge clock);
      #1;

      for (int a = 0; a < 64; a++) txn(4'hF, 12'(a), $urandom, rd, re, lat);

      for (int i = 0; i < 11; i++) begin
         txn(vt[i].we, vt[i].addr, vt[i].wdata, rd, re, lat);
         chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
         chk($sformatf("vec%0d_rerr", i), 32'(re), 32'(vt[i].exp_rerr));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(READ_LAT));
      end

      // Write then read of the same word on consecutive accepts
      bus.rready = 1'b1;
      bus.req = 1'b1;
      bus.we = 4'hF;
      bus.addr = 12'h040;
      bus.wdata = 32'h0BADF00D;
      wait_gnt();
      @(posedge clock);
      #1 bus.we = 4'h0;
      wait_gnt();
      @(posedge clock);
      #1 bus.req = 1'b0;
      drain();

      // Backpressure: consumer stalled, grant must stop at RSP_DEPTH outstanding
      bus.rready = 1'b0;
      bus.we = 4'h0;
      bus.addr = 12'h010;
      bus.req = 1'b1;
      cnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         acc = bus.gnt;
         @(posedge clock);
         #1;
         if (acc) begin
            cnt++;
            bus.addr = bus.addr + 12'd1;
         end
      end
      bus.req = 1'b0;
      chk("bp_accepts", 32'(cnt), 32'(RSP_DEPTH));
      bus.rready = 1'b1;
      @(negedge clock);
      chk("bp_gnt_before_pop", 32'(bus.gnt), 32'd0);
      chk("bp_rvalid", 32'(bus.rvalid), 32'd1);
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("bp_gnt_after_pop", 32'(bus.gnt), 32'd1);
      @(posedge clock);
      #1;
      drain();

      // Streaming reads of words 0..15 with the consumer always ready
      bus.rready = 1'b1;
      bus.we = 4'h0;
      bus.addr = 12'h000;
      bus.req = 1'b1;
      idx = 0;
      first_acc = -1;
      last_acc = -1;
      first_rv = -1;
      last_rv = -1;
      nrv = 0;
      gaps = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         if (bus.rvalid) begin
            if (first_rv < 0) first_rv = k;
            else if (k != last_rv + 1) gaps++;
            last_rv = k;
            nrv++;
         end
         acc = bus.req && bus.gnt;
         if (acc) begin
            if (first_acc < 0) first_acc = k;
            last_acc = k;
         end
         @(posedge clock);
         #1;
         if (acc) begin
            idx++;
            if (idx == 16) bus.req = 1'b0;
            else bus.addr = 12'(idx);
         end
      end
      chk("stream_accepts", 32'(idx), 32'd16);
      chk("stream_accept_span", 32'(last_acc - first_acc), 32'd15);
      chk("stream_rvalid_count", 32'(nrv), 32'd16);
      chk("stream_first_latency", 32'(first_rv - first_acc), 32'(READ_LAT));
      chk("stream_gaps", 32'(gaps), 32'd0);
      drain();

      // Reset with responses outstanding
      txn(4'hF, 12'h030, 32'h5A5AA5A5, rd, re, lat);
      bus.rready = 1'b0;
      bus.we = 4'h0;
      bus.addr = 12'h030;
      bus.req = 1'b1;
      cnt = 0;
      guard = 0;
      while (cnt < 3 && guard < 20) begin
         @(negedge clock);
         if (bus.gnt) cnt++;
         guard++;
         @(posedge clock);
         #1;
      end
      bus.req = 1'b0;
      chk("rst_seq_accepts", 32'(cnt), 32'd3);
      repeat (4) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_low_rvalid", 32'(bus.rvalid), 32'd0);
      chk("rst_low_rdata", bus.rdata, 32'd0);
      chk("rst_low_gnt", 32'(bus.gnt), 32'd0);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      chk("rst_release_rvalid", 32'(bus.rvalid), 32'd0);
      chk("rst_release_gnt", 32'(bus.gnt), 32'd1);
      @(posedge clock);
      #1;
      txn(4'h0, 12'h030, 32'h0, rd, re, lat);
      chk("rst_keeps_mem", rd, 32'h5A5AA5A5);

      // Random traffic against the model
      for (int c = 0; c < 500; c++) begin
         if (!bus.req && $urandom_range(0, 2) != 0) begin
            bus.req = 1'b1;
            bus.we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            bus.addr = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(DEPTH, 4095))
                                                   : 12'($urandom_range(0, 63));
            bus.wdata = $urandom;
         end
         bus.rready = ($urandom_range(0, 3) != 0);
         @(negedge clock);
         acc = bus.req && bus.gnt;
         @(posedge clock);
         #1;
         if (acc) bus.req = 1'b0;
      end
      bus.req = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
